// File: rtl/calc_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// calc_cmd_sequencer
//
// Sits between the keypad front end and the calc datapath. Key codes are
// queued in a small FIFO and handed to calc one at a time. Each code is held
// on calc_cmd until calc reports busy. The next code goes out only after calc
// has reported ready again. An error report from calc freezes the block until
// reset.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high
//   key_valid    in   key code present this cycle
//   key_code     in   4-bit key code (passed through unmodified)
//   key_ready    out  combinational: !full && !err && !flush
//   flush        in   discard all queued codes at the next edge
//   calc_status  in   00 error, 01 busy, 10 ready
//   calc_cmd     out  registered command to calc (IDLE_CMD when nothing issued)
//   busy         out  registered, high while a command is issued or awaited
//   err          out  registered, sticky error flag
//   timeout      out  registered, one-cycle pulse when a command is dropped
//   fill         out  registered FIFO occupancy
// -----------------------------------------------------------------------------
module calc_cmd_sequencer #(
    parameter int         DEPTH    = 8,
    parameter int         TIMEOUT  = 1000,
    parameter logic [3:0] IDLE_CMD = 4'b1101
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     key_valid,
    input  logic [3:0]               key_code,
    output logic                     key_ready,
    input  logic                     flush,
    input  logic [1:0]               calc_status,
    output logic [3:0]               calc_cmd,
    output logic                     busy,
    output logic                     err,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    localparam logic [1:0] STAT_ERROR = 2'b00;
    localparam logic [1:0] STAT_BUSY  = 2'b01;
    localparam logic [1:0] STAT_READY = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [3:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [15:0]     timer;
    logic [15:0]     timer_nxt;

    logic            full;
    logic            push;
    logic            pop;
    logic            drop;
    logic            fifo_clr;
    logic [FW-1:0]   fill_nxt;
    logic [3:0]      cmd_nxt;
    logic            busy_nxt;
    logic            err_nxt;
    logic            timeout_nxt;

    // State register: FSM state, registered outputs and FIFO control.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            calc_cmd <= IDLE_CMD;
            busy     <= 1'b0;
            err      <= 1'b0;
            timeout  <= 1'b0;
            fill     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            timer    <= '0;
        end else begin
            state    <= state_nxt;
            calc_cmd <= cmd_nxt;
            busy     <= busy_nxt;
            err      <= err_nxt;
            timeout  <= timeout_nxt;
            fill     <= fill_nxt;
            timer    <= timer_nxt;
            if (fifo_clr) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Storage carries data only, so it has no reset.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= key_code;
    end

    // Next-state logic. An error report overrides every other transition,
    // which also suppresses a pop or a timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        pop       = 1'b0;
        drop      = 1'b0;
        if (calc_status == STAT_ERROR) begin
            state_nxt = ST_ERROR;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A flush discards the whole queue, head included, so it
                    // also holds off an issue in the same cycle.
                    if (fill != '0 && calc_status == STAT_READY && !flush) begin
                        state_nxt = ST_ISSUE;
                        pop       = 1'b1;
                        timer_nxt = '0;
                    end
                end
                ST_ISSUE: begin
                    if (calc_status == STAT_BUSY) begin
                        state_nxt = ST_WAIT;
                    end else if (timer == 16'(TIMEOUT - 1)) begin
                        state_nxt = ST_IDLE;
                        drop      = 1'b1;
                    end else begin
                        timer_nxt = timer + 16'd1;
                    end
                end
                ST_WAIT: begin
                    if (calc_status == STAT_READY) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_ERROR;
            endcase
        end
    end

    // Output logic: handshake plus next values of the registered outputs.
    always_comb begin
        full      = (fill == FW'(DEPTH));
        key_ready = !full && !err && !flush;
        push      = key_valid && key_ready;
        fifo_clr  = flush || (state_nxt == ST_ERROR);

        // A pop in the same cycle never frees a slot for the push, because
        // key_ready already looked at the current fill.
        fill_nxt = fill;
        if (fifo_clr) begin
            fill_nxt = '0;
        end else if (push && !pop) begin
            fill_nxt = fill + FW'(1);
        end else if (pop && !push) begin
            fill_nxt = fill - FW'(1);
        end

        cmd_nxt = IDLE_CMD;
        if (pop) begin
            cmd_nxt = mem[rd_ptr];
        end else if (state == ST_ISSUE && state_nxt == ST_ISSUE) begin
            cmd_nxt = calc_cmd;
        end

        busy_nxt    = (state_nxt == ST_ISSUE) || (state_nxt == ST_WAIT);
        err_nxt     = (state_nxt == ST_ERROR);
        timeout_nxt = drop;
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_cmd_sequencer
//
// Drives directed scenarios followed by randomized traffic into
// calc_cmd_sequencer (DEPTH=8, TIMEOUT=4) and compares every output once per
// cycle against a queue-based behavioural model of the sequencer.
// -----------------------------------------------------------------------------
module tb_calc_cmd_sequencer;

    localparam int         DEPTH    = 8;
    localparam int         TIMEOUT  = 4;
    localparam logic [3:0] IDLE_CMD = 4'b1101;

    logic        clock;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic        flush;
    logic [1:0]  calc_status;
    logic [3:0]  calc_cmd;
    logic        busy;
    logic        err;
    logic        timeout;
    logic [3:0]  fill;

    int vectors;
    int miscompares;

    calc_cmd_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .IDLE_CMD(IDLE_CMD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .flush      (flush),
        .calc_status(calc_status),
        .calc_cmd   (calc_cmd),
        .busy       (busy),
        .err        (err),
        .timeout    (timeout),
        .fill       (fill)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: a queue of pending codes plus what calc is being
    // told right now.
    logic [3:0] q[$];
    logic [3:0] m_cmd;
    bit         m_issuing;
    bit         m_waiting;
    bit         m_err;
    bit         m_to;
    int         m_hold;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cmd     = IDLE_CMD;
        m_issuing = 0;
        m_waiting = 0;
        m_err     = 0;
        m_to      = 0;
        m_hold    = 0;
    endtask

    task automatic model_clock(input logic kv, input logic [3:0] code, input logic fl,
                               input logic [1:0] st);
        bit accept;
        accept = kv && (q.size() < DEPTH) && !m_err && !fl;
        m_to   = 0;
        if (st == 2'b00) begin
            m_err     = 1;
            m_issuing = 0;
            m_waiting = 0;
            m_cmd     = IDLE_CMD;
            q.delete();
        end else if (!m_err) begin
            if (m_issuing) begin
                if (st == 2'b01) begin
                    m_issuing = 0;
                    m_waiting = 1;
                    m_cmd     = IDLE_CMD;
                end else if (m_hold == TIMEOUT - 1) begin
                    m_issuing = 0;
                    m_to      = 1;
                    m_cmd     = IDLE_CMD;
                end else begin
                    m_hold++;
                end
            end else if (m_waiting) begin
                if (st == 2'b10) m_waiting = 0;
            end else if (q.size() > 0 && st == 2'b10 && !fl) begin
                m_cmd     = q.pop_front();
                m_issuing = 1;
                m_hold    = 0;
            end
            if (fl) q.delete();
            else if (accept) q.push_back(code);
        end
    endtask

    task automatic check_outputs(input string where, input logic fl);
        check_val({where, "_calc_cmd"}, 16'(calc_cmd), 16'(m_cmd));
        check_val({where, "_busy"}, 16'(busy), 16'(m_issuing || m_waiting));
        check_val({where, "_err"}, 16'(err), 16'(m_err));
        check_val({where, "_timeout"}, 16'(timeout), 16'(m_to));
        check_val({where, "_fill"}, 16'(fill), 16'(q.size()));
        check_val({where, "_key_ready"}, 16'(key_ready),
                  16'((q.size() < DEPTH) && !m_err && !fl));
    endtask

    // One clock cycle: inputs applied just after an edge, outputs checked on
    // the falling edge, model advanced, then the next rising edge.
    task automatic step(input string where, input logic kv, input logic [3:0] code,
                        input logic fl, input logic [1:0] st);
        key_valid   = kv;
        key_code    = code;
        flush       = fl;
        calc_status = st;
        @(negedge clock);
        check_outputs(where, fl);
        model_clock(kv, code, fl, st);
        @(posedge clock);
        #1;
    endtask

    // Asynchronous reset: outputs must return to reset values before any edge.
    task automatic do_reset(input string where);
        key_valid   = 1'b0;
        flush       = 1'b0;
        calc_status = 2'b10;
        reset       = 1'b1;
        #1;
        model_reset();
        check_val({where, "_rst_calc_cmd"}, 16'(calc_cmd), 16'(IDLE_CMD));
        check_val({where, "_rst_busy"}, 16'(busy), 16'd0);
        check_val({where, "_rst_err"}, 16'(err), 16'd0);
        check_val({where, "_rst_timeout"}, 16'(timeout), 16'd0);
        check_val({where, "_rst_fill"}, 16'(fill), 16'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Calc handshake for one issued code: ready, then busy for 3 cycles.
    task automatic calc_round(input string where);
        step(where, 1'b0, 4'd0, 1'b0, 2'b10);
        for (int k = 0; k < 3; k++) step(where, 1'b0, 4'd0, 1'b0, 2'b01);
    endtask

    logic [3:0] seq4 [4];

    initial begin
        vectors     = 0;
        miscompares = 0;
        key_code    = 4'd0;
        seq4[0] = 4'd3; seq4[1] = 4'b1010; seq4[2] = 4'd4; seq4[3] = 4'b1110;

        do_reset("init");
        step("reset_state", 1'b0, 4'd0, 1'b0, 2'b10);

        // Ordered issue with busy held for 3 cycles per code.
        for (int i = 0; i < 4; i++) step("order_push", 1'b1, seq4[i], 1'b0, 2'b01);
        for (int i = 0; i < 4; i++) calc_round("order_run");
        for (int i = 0; i < 3; i++) step("order_end", 1'b0, 4'd0, 1'b0, 2'b10);

        // FIFO full: 9 pushes while calc is busy, then drain in order.
        for (int i = 0; i < 9; i++) step("full_push", 1'b1, 4'(i + 1), 1'b0, 2'b01);
        step("full_hold", 1'b1, 4'd15, 1'b0, 2'b01);
        for (int i = 0; i < 8; i++) calc_round("full_drain");
        for (int i = 0; i < 3; i++) step("full_end", 1'b0, 4'd0, 1'b0, 2'b10);

        // Timeout: calc never reports busy; two codes queued.
        step("to_push", 1'b1, 4'd7, 1'b0, 2'b10);
        step("to_push", 1'b1, 4'd2, 1'b0, 2'b10);
        for (int i = 0; i < 12; i++) step("to_run", 1'b0, 4'd0, 1'b0, 2'b10);

        // Simultaneous push and pop at fill=DEPTH-1.
        for (int i = 0; i < DEPTH - 1; i++) step("pp_fill", 1'b1, 4'(i), 1'b0, 2'b01);
        step("pp_both", 1'b1, 4'd9, 1'b0, 2'b10);
        step("pp_after", 1'b1, 4'd8, 1'b0, 2'b01);
        do_reset("pp");

        // Error mid-ISSUE with codes queued, then pushes ignored.
        for (int i = 0; i < 4; i++) step("err_push", 1'b1, 4'(i + 3), 1'b0, 2'b01);
        step("err_issue", 1'b0, 4'd0, 1'b0, 2'b10);
        step("err_in_issue", 1'b0, 4'd0, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) step("err_sticky", 1'b1, 4'(i), 1'b0, 2'b10);
        do_reset("err");

        // Error coinciding with a pop.
        step("errpop_push", 1'b1, 4'd5, 1'b0, 2'b10);
        step("errpop_hit", 1'b0, 4'd0, 1'b0, 2'b00);
        step("errpop_after", 1'b0, 4'd0, 1'b0, 2'b10);
        do_reset("errpop");

        // Flush while in WAIT with a same-cycle push.
        for (int i = 0; i < 5; i++) step("fl_push", 1'b1, 4'(i + 10), 1'b0, 2'b01);
        step("fl_issue", 1'b0, 4'd0, 1'b0, 2'b10);
        step("fl_busy", 1'b0, 4'd0, 1'b0, 2'b01);
        step("fl_flush", 1'b1, 4'd6, 1'b1, 2'b01);
        step("fl_wait", 1'b0, 4'd0, 1'b0, 2'b01);
        for (int i = 0; i < 3; i++) step("fl_done", 1'b0, 4'd0, 1'b0, 2'b10);

        // Async reset asserted during ISSUE.
        step("ar_push", 1'b1, 4'd8, 1'b0, 2'b10);
        step("ar_push", 1'b1, 4'd1, 1'b0, 2'b10);
        step("ar_issue", 1'b0, 4'd0, 1'b0, 2'b10);
        #1;
        do_reset("ar_mid_issue");
        step("ar_after", 1'b0, 4'd0, 1'b0, 2'b10);

        // Randomized traffic, with a fresh reset per block.
        for (int blk = 0; blk < 6; blk++) begin
            do_reset("rnd");
            for (int i = 0; i < 300; i++) begin
                int         r;
                logic [1:0] st;
                r  = int'($urandom_range(0, 199));
                st = (r < 1) ? 2'b00 : (r < 70) ? 2'b01 : 2'b10;
                step("rnd", 1'($urandom_range(0, 1)), 4'($urandom),
                     ($urandom_range(0, 39) == 0), st);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_cmd_sequencer.md
# calc_cmd_sequencer

Command sequencer between the keypad front end and the `calc` datapath. Key codes are buffered in a FIFO and issued to `calc` one at a time. Each code is held on `calc_cmd` until the calculator reports busy (`calc_status`=01). The next code is issued only after the calculator reports ready (10) again. An error report (00) freezes the block until reset.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- TIMEOUT, 1000: cycles allowed in ISSUE for busy to appear; range 1 to 65535.
- IDLE_CMD, 4'b1101: code driven on `calc_cmd` when no command is being issued.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- key_valid  in  1  key code present this cycle.
- key_code  in  4  0-9 digit, 1010-1100 operator, 1110 equals, 1111 backspace.
- key_ready  out  1  combinational: !full && !err && !flush.
- flush  in  1  discard all queued codes.
- calc_status  in  2  00 error, 01 busy, 10 ready.
- calc_cmd  out  4  registered command to `calc`.
- busy  out  1  registered; 1 in ISSUE or WAIT.
- err  out  1  registered, sticky error flag.
- timeout  out  1  registered; one-cycle pulse when a command is dropped.
- fill  out  $clog2(DEPTH)+1  registered FIFO occupancy.

## Operation
- FIFO:
  - Push when key_valid && key_ready.
  - Pop only on the IDLE->ISSUE transition.
  - Full: fill==DEPTH. No push bypass when full; a same-cycle pop does not free a slot for that cycle's push.
  - Pointers wrap modulo DEPTH. Occupancy is a separate counter.
- flush:
  - Clears pointers and fill at the next edge.
  - key_ready=0 while flush=1, so a same-cycle push is dropped.
  - Does not abort a command already in ISSUE or WAIT.
- IDLE (calc_cmd=IDLE_CMD, busy=0):
  - If fill>0 and calc_status==10: pop the head, calc_cmd<=head, clear the timer, go to ISSUE.
- ISSUE (calc_cmd holds the code):
  - calc_status==01: calc_cmd<=IDLE_CMD, go to WAIT.
  - Otherwise the timer increments. When timer==TIMEOUT-1: timeout<=1 for one cycle, calc_cmd<=IDLE_CMD, the code is discarded, go to IDLE.
- WAIT (calc_cmd=IDLE_CMD):
  - calc_status==10: go to IDLE.
  - No timeout in WAIT; multiplication may be long.
- ERROR:
  - Entered from any state at the edge after calc_status==00 is sampled. This has priority over every other transition.
  - On entry: err<=1, calc_cmd<=IDLE_CMD, busy<=0, FIFO cleared.
  - key_ready=0 in ERROR; pushes are ignored.
  - Left only by reset.
- Codes are passed through unmodified. The sequencer does not check grammar.

## Timing
- Reset (asynchronous):
  - State IDLE.
  - calc_cmd=IDLE_CMD, busy=0, err=0, timeout=0, fill=0.
  - FIFO empty; key_ready=1 once reset deasserts.
- Reset mid-command: the in-flight code and queued codes are lost. calc_cmd returns to IDLE_CMD immediately, asynchronously.
- Push at edge N into an empty FIFO, with calc_status==10 during cycle N+1: fill=1 after edge N, calc_cmd=code after edge N+1, busy=1 after N+1, fill=0 after N+1.
- Hold time: calc_cmd holds the code from the ISSUE entry edge until the edge after busy is first sampled. Minimum hold is one cycle.
- Back-to-back issue: at least one cycle of ready (10) must be sampled in WAIT, plus one cycle in IDLE, before the next issue.
- Simultaneous push and pop at fill=DEPTH-1: both occur, fill unchanged. At fill=DEPTH, the push is refused.
- calc_status==00 in the same cycle as a timeout or pop: ERROR wins, timeout is not pulsed, and the pop is discarded.

## Test plan
- Ordered issue: after reset, push 3, 1010, 4, 1110 with calc_status toggling 10->01 (3 cycles)->10. Required: calc_cmd shows 3, 1010, 4, 1110 in order, each until busy is sampled, IDLE_CMD between codes, fill ends at 0.
- FIFO full with DEPTH=8: hold calc_status=01 and push 9 codes. Required: key_ready=0 after the 8th push, the 9th code is dropped, fill=8; after release all 8 codes are issued in order.
- Timeout with TIMEOUT=4: push 7 and hold calc_status=10. Required: calc_cmd=7 for 4 cycles, one timeout pulse, then calc_cmd=IDLE_CMD and the next queued code is issued.
- Error: with 3 codes queued mid-ISSUE, drive calc_status=00 for one cycle. Required: the next edge gives err=1, fill=0, calc_cmd=IDLE_CMD, key_ready=0; later pushes are ignored until reset.
- Flush: queue 5 codes, then assert flush with key_valid in the same cycle while in WAIT. Required: fill=0, the pushed code is dropped, and the in-flight command completes normally.
- Async reset asserted during ISSUE. Required: calc_cmd=IDLE_CMD and busy=0 before the next clock edge, and all outputs at their reset values.
